fifo_param: RTL and testbench

// - Parametrised single-clock FIFO, first-word-fall-through: read_data shows the head entry whenever !empty.
// - Generalises the fixed 8-bit FIFO in width and depth.
// - Adds a fill count, programmable almost-full/almost-empty flags and optional sticky error flags.
// - Sits between producer/consumer blocks in one clock domain (pixel pipelines, SRAM/UART staging).
//

---
 rtl/fifo_param_if.sv | 28 ++
 rtl/fifo_param.sv | 81 ++++++++
 tb/tb_fifo_param.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_param_if.sv
// Handshake/status bundle for fifo_param. "master" is the producer/consumer side; "slave" is the FIFO.
interface fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  write_en;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clear;

  modport master (
    output write_en, write_data, read_en, err_clear,
    input  read_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  write_en, write_data, read_en, err_clear,
    output read_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock first-word-fall-through FIFO with fill count and threshold flags.
// Define FIFO_PARAM_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic         clk,
  input  logic         reset,
  fifo_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LVL = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL = AE_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   fill;
  logic                  empty_w;
  logic                  full_w;
  logic                  wr_accept;
  logic                  rd_accept;

  // Status comes only from the registered pointers, never from this cycle's requests.
  assign fill    = wr_ptr - rd_ptr;
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  assign wr_accept = bus.write_en && !full_w;
  assign rd_accept = bus.read_en && !empty_w;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.write_data;
  end

  assign bus.read_data    = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign bus.count        = fill;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (fill <= AE_LVL);
  assign bus.almost_full  = (fill >= AF_LVL);

`ifdef FIFO_PARAM_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // A set event wins over a coincident clear so no error is ever lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.write_en && full_w)      ovf_q <= 1'b1;
      else if (bus.err_clear)          ovf_q <= 1'b0;
      if (bus.read_en && empty_w)      unf_q <= 1'b1;
      else if (bus.err_clear)          unf_q <= 1'b0;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = bus.err_clear;
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (16 deep, 8 bit), covering both error-flag builds.
module tb_fifo_param;
`ifdef FIFO_PARAM_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  fifo_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin : stim
    logic [7:0] exp_rd;
    logic [7:0] wval;
    bus.write_en   = 1'b0;
    bus.write_data = '0;
    bus.read_en    = 1'b0;
    bus.err_clear  = 1'b0;

    // Reset held for 3 cycles
    repeat (3) tick();
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
    chk("rst_af", 32'(bus.almost_full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_unf", 32'(bus.underflow), 32'd0);
    reset = 1'b1;
    tick();

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      bus.write_en   = 1'b1;
      bus.write_data = 8'(i);
      tick();
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_af", 32'(bus.almost_full), 32'((i + 1) >= 14));
      chk("fill_ae", 32'(bus.almost_empty), 32'((i + 1) <= 2));
      chk("fill_full", 32'(bus.full), 32'((i + 1) == 16));
    end
    bus.write_data = 8'hAA;
    tick();
    bus.write_en = 1'b0;
    chk("ovf_count", 32'(bus.count), 32'd16);
    chk("ovf_full", 32'(bus.full), 32'd1);
    chk("ovf_flag", 32'(bus.overflow), 32'(ERR_EN));

    // Drain in order; 0xAA must never surface
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(bus.read_data), 32'(i));
      bus.read_en = 1'b1;
      tick();
      chk("drain_count", 32'(bus.count), 32'(15 - i));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    tick();
    bus.read_en = 1'b0;
    chk("unf_count", 32'(bus.count), 32'd0);
    chk("unf_flag", 32'(bus.underflow), 32'(ERR_EN));
    chk("ovf_sticky", 32'(bus.overflow), 32'(ERR_EN));
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    chk("clr_unf", 32'(bus.underflow), 32'd0);

    // Full boundary: simultaneous write+read pops, drops the write
    for (int i = 0; i < 16; i++) begin
      bus.write_en   = 1'b1;
      bus.write_data = 8'(8'h20 + i);
      tick();
    end
    chk("bf_full", 32'(bus.full), 32'd1);
    chk("bf_head", 32'(bus.read_data), 32'h20);
    bus.write_data = 8'hEE;
    bus.read_en    = 1'b1;
    tick();
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    chk("bf_count", 32'(bus.count), 32'd15);
    chk("bf_next", 32'(bus.read_data), 32'h21);
    for (int i = 1; i < 16; i++) begin
      chk("bf_drain", 32'(bus.read_data), 32'(8'h20 + i));
      bus.read_en = 1'b1;
      tick();
    end
    chk("bf_empty", 32'(bus.empty), 32'd1);

    // Empty boundary: read ignored, write lands and appears next cycle
    bus.write_en   = 1'b1;
    bus.write_data = 8'h77;
    bus.read_en    = 1'b1;
    tick();
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    chk("be_count", 32'(bus.count), 32'd1);
    chk("be_empty", 32'(bus.empty), 32'd0);
    chk("be_data", 32'(bus.read_data), 32'h77);
    chk("be_unf", 32'(bus.underflow), 32'(ERR_EN));
    bus.read_en   = 1'b1;
    bus.err_clear = 1'b1;
    tick();
    bus.read_en   = 1'b0;
    bus.err_clear = 1'b0;
    chk("be_pop_empty", 32'(bus.empty), 32'd1);

    // Interleave: write whenever not full, pop every 20th cycle
    exp_rd = 8'h00;
    wval   = 8'h00;
    for (int cyc = 0; cyc < 512; cyc++) begin
      bus.write_en   = !bus.full;
      bus.write_data = wval;
      bus.read_en    = ((cyc % 20) == 19) && !bus.empty;
      if (bus.read_en) begin
        chk("il_order", 32'(bus.read_data), 32'(exp_rd));
        exp_rd = exp_rd + 8'd1;
      end
      if (bus.write_en) wval = wval + 8'd1;
      tick();
    end
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    chk("il_full", 32'(bus.full), 32'd1);
    chk("il_head", 32'(bus.read_data), 32'(exp_rd));
    chk("il_ovf", 32'(bus.overflow), 32'd0);

    // Mid-stream reset with 5 entries held
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.write_en   = 1'b1;
      bus.write_data = 8'(8'h40 + i);
      tick();
    end
    bus.write_en = 1'b0;
    chk("mr_count5", 32'(bus.count), 32'd5);
    reset = 1'b0;
    #1;
    chk("mr_count", 32'(bus.count), 32'd0);
    chk("mr_empty", 32'(bus.empty), 32'd1);
    tick();
    reset = 1'b1;
    bus.write_en   = 1'b1;
    bus.write_data = 8'h5A;
    tick();
    bus.write_en = 1'b0;
    chk("mr_first", 32'(bus.read_data), 32'h5A);
    chk("mr_count1", 32'(bus.count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
